// File: rtl/path_read_buffer.sv
// Read-path buffer between DRAM read-data return and the AES/stash consumer.
// First-word fall-through FIFO with path tracking and optional whole-path release.
module path_read_buffer #(
    parameter int Width        = 512,
    parameter int Depth        = 64,
    parameter int PathBursts   = 40,
    parameter int StoreForward = 0,
    localparam int CountW      = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [Width-1:0]  in_data_i,
    input  logic              in_valid_i,
    output logic              in_accept_o,
    output logic [Width-1:0]  out_data_o,
    output logic              out_send_o,
    input  logic              out_ready_i,
    output logic [CountW-1:0] count_o,
    output logic              overflow_o,
    output logic              path_done_o
);

    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int PW = (PathBursts > 1) ? $clog2(PathBursts) : 1;
    localparam logic [CountW-1:0] FullCount  = CountW'(Depth);
    localparam logic [CountW-1:0] PathCredit = CountW'(PathBursts);
    localparam logic [AW-1:0]     LastSlot   = AW'(Depth - 1);
    localparam logic [PW-1:0]     LastBurst  = PW'(PathBursts - 1);

    if (Depth < 2) begin : g_err_depth
        $error("path_read_buffer: Depth must be at least 2");
    end
    if (PathBursts < 1) begin : g_err_bursts
        $error("path_read_buffer: PathBursts must be at least 1");
    end
    if (StoreForward != 0 && PathBursts > Depth) begin : g_err_sf
        $error("path_read_buffer: store-and-forward needs PathBursts <= Depth");
    end

    logic [Width-1:0]  mem_q [Depth];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic [CountW-1:0] rel_q, rel_d;
    logic [PW-1:0]     in_cnt_q, in_cnt_d;
    logic [PW-1:0]     out_cnt_q, out_cnt_d;
    logic              overflow_q, overflow_d;
    logic              path_done_q, path_done_d;
    logic              push, pop, in_wrap, out_wrap;

    // No full bypass: acceptance looks only at registered occupancy.
    assign in_accept_o = !rst_i && (count_q != FullCount);
    assign out_send_o  = (count_q != '0) && ((StoreForward == 0) || (rel_q != '0));
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign path_done_o = path_done_q;

    assign push     = in_valid_i && in_accept_o;
    assign pop      = out_send_o && out_ready_i;
    assign in_wrap  = push && (in_cnt_q == LastBurst);
    assign out_wrap = pop && (out_cnt_q == LastBurst);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rel_d       = rel_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        overflow_d  = overflow_q || (in_valid_i && !in_accept_o);
        path_done_d = out_wrap;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + AW'(1);
            in_cnt_d = in_wrap ? '0 : in_cnt_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d  = (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + AW'(1);
            out_cnt_d = out_wrap ? '0 : out_cnt_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
        endcase

        // Credits: a completed path releases PathBursts entries, each pop spends one.
        case ({in_wrap, pop})
            2'b10:   rel_d = rel_q + PathCredit;
            2'b01:   rel_d = rel_q - CountW'(1);
            2'b11:   rel_d = rel_q + PathCredit - CountW'(1);
            default: rel_d = rel_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rel_q       <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            path_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rel_q       <= rel_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            overflow_q  <= overflow_d;
            path_done_q <= path_done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

`ifdef SIMULATION
    always_ff @(posedge clk_i) begin
        if (!rst_i && in_valid_i && !in_accept_o) begin
            $display("path_read_buffer: ERROR read burst dropped, buffer full");
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_path_read_buffer.sv
// Directed bench for path_read_buffer: a cut-through and a store-and-forward
// instance share stimulus and are both checked against a queue-based model.
module tb_path_read_buffer;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int PB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic         acc [2];
    logic         send [2];
    logic         ovf [2];
    logic         pd [2];
    logic [W-1:0] dat [2];
    logic [3:0]   cnt [2];

    path_read_buffer #(.Width(W), .Depth(D), .PathBursts(PB), .StoreForward(0)) u_ct (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_accept_o(acc[0]), .out_data_o(dat[0]), .out_send_o(send[0]),
        .out_ready_i(out_ready), .count_o(cnt[0]), .overflow_o(ovf[0]),
        .path_done_o(pd[0]));

    path_read_buffer #(.Width(W), .Depth(D), .PathBursts(PB), .StoreForward(1)) u_sf (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_accept_o(acc[1]), .out_data_o(dat[1]), .out_send_o(send[1]),
        .out_ready_i(out_ready), .count_o(cnt[1]), .overflow_o(ovf[1]),
        .path_done_o(pd[1]));

    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 1'b0;
    int pd_cnt1 = 0;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Model: instance 0 cut-through, instance 1 releases whole paths only.
    logic [W-1:0] mq0[$];
    logic [W-1:0] mq1[$];
    int m_in [2];
    int m_out [2];
    int m_rel [2];
    bit m_ovf [2];
    bit m_pd [2];

    function automatic int qsize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [W-1:0] qfront(input int k);
        return (k == 0) ? mq0[0] : mq1[0];
    endfunction

    function automatic bit m_send(input int k);
        return (qsize(k) != 0) && (k == 0 || m_rel[k] != 0);
    endfunction

    always @(posedge clk) begin
        bit a, s, po, pu;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                if (k == 0) mq0.delete(); else mq1.delete();
                m_in[k] = 0; m_out[k] = 0; m_rel[k] = 0; m_ovf[k] = 0; m_pd[k] = 0;
            end else begin
                a  = (qsize(k) != D);
                s  = m_send(k);
                po = s && out_ready;
                pu = in_valid && a;
                if (in_valid && !a) m_ovf[k] = 1'b1;
                m_pd[k] = po && (m_out[k] == PB - 1);
                if (po) begin
                    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                    m_out[k] = (m_out[k] + 1) % PB;
                    m_rel[k] = m_rel[k] - 1;
                end
                if (pu) begin
                    if (k == 0) mq0.push_back(in_data); else mq1.push_back(in_data);
                    if (m_in[k] == PB - 1) begin
                        m_in[k] = 0;
                        m_rel[k] = m_rel[k] + PB;
                    end else begin
                        m_in[k] = m_in[k] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                check("accept", k, 32'(acc[k]), 32'(!rst && qsize(k) != D));
                check("send", k, 32'(send[k]), 32'(m_send(k)));
                check("count", k, 32'(cnt[k]), 32'(qsize(k)));
                check("overflow", k, 32'(ovf[k]), 32'(m_ovf[k]));
                check("path_done", k, 32'(pd[k]), 32'(m_pd[k]));
                if (m_send(k)) check("data", k, 32'(dat[k]), 32'(qfront(k)));
            end
            if (pd[1] === 1'b1) pd_cnt1++;
        end
    end

    task automatic step(input bit v, input logic [W-1:0] d, input bit r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_accept_low", 0, 32'(acc[0]), 32'd0);
        step(1'b0, '0, 1'b0);
        armed = 1'b1;
        check("rst_count", 0, 32'(cnt[0]), 32'd0);
        check("rst_send", 1, 32'(send[1]), 32'd0);
        check("rst_overflow", 0, 32'(ovf[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_accept_high", 1, 32'(acc[1]), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Scenario 1: cut-through streaming path
        do_reset();
        step(1'b1, 16'h00A1, 1'b1);
        check("s1_send", 0, 32'(send[0]), 32'd1);
        check("s1_data", 0, 32'(dat[0]), 32'h00A1);
        step(1'b1, 16'h00A2, 1'b1);
        check("s1_data2", 0, 32'(dat[0]), 32'h00A2);
        check("s1_count", 0, 32'(cnt[0]), 32'd1);
        step(1'b1, 16'h00A3, 1'b1);
        step(1'b1, 16'h00A4, 1'b1);
        step(1'b0, '0, 1'b1);
        check("s1_pathdone", 0, 32'(pd[0]), 32'd1);
        check("s1_empty", 0, 32'(send[0]), 32'd0);
        repeat (6) step(1'b0, '0, 1'b1);

        // Scenario 2: fill, overflow, drain in order
        do_reset();
        for (int i = 0; i < D; i++) step(1'b1, 16'hB000 + 16'(i), 1'b0);
        check("s2_full_count", 0, 32'(cnt[0]), 32'd8);
        check("s2_full_accept", 0, 32'(acc[0]), 32'd0);
        step(1'b1, 16'h0BAD, 1'b0);
        check("s2_overflow", 0, 32'(ovf[0]), 32'd1);
        step(1'b0, '0, 1'b0);
        check("s2_sticky", 1, 32'(ovf[1]), 32'd1);
        for (int i = 0; i < D; i++) begin
            check("s2_order", 0, 32'(dat[0]), 32'hB000 + 32'(i));
            step(1'b0, '0, 1'b1);
        end
        check("s2_drained", 0, 32'(cnt[0]), 32'd0);

        // Scenario 3: full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < D; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0);
        step(1'b1, 16'h0CCC, 1'b1);
        check("s3_count", 0, 32'(cnt[0]), 32'd7);
        check("s3_overflow", 0, 32'(ovf[0]), 32'd1);
        check("s3_accept", 0, 32'(acc[0]), 32'd1);
        check("s3_head", 0, 32'(dat[0]), 32'hC001);
        repeat (9) step(1'b0, '0, 1'b1);

        // Scenario 4: store-and-forward holds partial path
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 16'hE000 + 16'(i), 1'b1);
        check("s4_withheld", 1, 32'(send[1]), 32'd0);
        step(1'b1, 16'hE003, 1'b1);
        check("s4_release", 1, 32'(send[1]), 32'd1);
        check("s4_head", 1, 32'(dat[1]), 32'hE000);
        repeat (4) step(1'b0, '0, 1'b1);
        check("s4_done_send", 1, 32'(send[1]), 32'd0);
        check("s4_pathdone", 1, 32'(pd[1]), 32'd1);
        step(1'b0, '0, 1'b1);

        // Scenario 5: next path pushed while previous drains
        do_reset();
        pd_cnt1 = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 16'hF000 + 16'(i), 1'b1);
        step(1'b1, 16'hD000, 1'b1);
        step(1'b1, 16'hD001, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check("s5_partial_cnt", 1, 32'(cnt[1]), 32'd2);
        check("s5_withheld", 1, 32'(send[1]), 32'd0);
        repeat (2) step(1'b0, '0, 1'b1);
        check("s5_still_held", 1, 32'(send[1]), 32'd0);
        step(1'b1, 16'hD002, 1'b1);
        step(1'b1, 16'hD003, 1'b1);
        check("s5_release", 1, 32'(send[1]), 32'd1);
        check("s5_head", 1, 32'(dat[1]), 32'hD000);
        repeat (5) step(1'b0, '0, 1'b1);
        check("s5_pathdone_count", 1, 32'(pd_cnt1), 32'd2);

        // Scenario 6: reset in the middle of a path
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 16'h6000 + 16'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        check("s6_count5", 0, 32'(cnt[0]), 32'd5);
        rst = 1'b1;
        step(1'b1, 16'h0666, 1'b0);
        check("s6_count0", 1, 32'(cnt[1]), 32'd0);
        check("s6_send0", 0, 32'(send[0]), 32'd0);
        check("s6_ovf0", 1, 32'(ovf[1]), 32'd0);
        rst = 1'b0;
        #1;
        check("s6_accept", 0, 32'(acc[0]), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h00A1 + 16'(i), 1'b1);
        check("s6_sf_release", 1, 32'(send[1]), 32'd1);
        step(1'b0, '0, 1'b1);
        check("s6_pathdone", 0, 32'(pd[0]), 32'd1);
        repeat (5) step(1'b0, '0, 1'b1);
        check("s6_sf_empty", 1, 32'(cnt[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
